// File: rtl/axi_r_beat_packer.sv
// Packs buffered memory response words into AXI R beats for queued read bursts.
// One registered output beat decouples the response FIFO head from the R channel.
module axi_r_beat_packer #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_BANKS     = 1,
    parameter int ID_WIDTH      = 4,
    parameter int LEN_WIDTH     = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ID_WIDTH-1:0]      cmd_id_i,
    input  logic [LEN_WIDTH-1:0]     cmd_len_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [DATA_WIDTH-1:0]    resp_data_i,
    input  logic [NUM_BANKS-1:0]     resp_err_i,
    input  logic [NUM_BANKS-1:0]     resp_exokay_i,
    input  logic                     resp_valid_i,
    output logic                     resp_ready_o,
    output logic [ID_WIDTH-1:0]      r_id_o,
    output logic [DATA_WIDTH-1:0]    r_data_o,
    output logic [1:0]               r_resp_o,
    output logic                     r_last_o,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    input  logic                     err_clr_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [ID_WIDTH-1:0]  id_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic                 out_free;
    logic                 pop;
    logic                 last_beat;
    logic                 cmd_take;
    logic                 r_hs;
    logic [1:0]           resp_enc;

    // Output slot can take a new beat if empty or draining this cycle.
    assign out_free  = ~r_valid_o | r_ready_i;
    assign pop       = resp_valid_i & (state_q == BURST) & out_free;
    assign last_beat = (cnt_q == len_q);
    assign cmd_take  = (state_q == IDLE) & cmd_valid_i;
    assign r_hs      = r_valid_o & r_ready_i;

    always_comb begin
        resp_enc = 2'b00;
        if (|resp_err_i) begin
            resp_enc = 2'b10;
        end else if (&resp_exokay_i) begin
            resp_enc = 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready_o  = 1'b0;
        resp_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                resp_ready_o = out_free;
                if (pop && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            r_id_o    <= '0;
            r_data_o  <= '0;
            r_resp_o  <= 2'b00;
            r_last_o  <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_take) begin
                id_q  <= cmd_id_i;
                len_q <= cmd_len_i;
                cnt_q <= '0;
            end
            if (pop) begin
                cnt_q     <= cnt_q + LEN_WIDTH'(1);
                r_id_o    <= id_q;
                r_data_o  <= resp_data_i;
                r_resp_o  <= resp_enc;
                r_last_o  <= last_beat;
                r_valid_o <= 1'b1;
            end else if (r_hs) begin
                r_valid_o <= 1'b0;
            end
        end
    end

    // Clear wins over a coincident SLVERR handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            err_cnt_o <= '0;
        end else if (r_hs && (r_resp_o == 2'b10) && !(&err_cnt_o)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axi_r_beat_packer.sv
// Directed bench for axi_r_beat_packer: bursts, stalls, resp encoding,
// mid-burst reset, 256-beat burst and error counter saturation.
module tb_axi_r_beat_packer;

    localparam int DW  = 32;
    localparam int NB  = 2;
    localparam int IDW = 4;
    localparam int LW  = 8;
    localparam int ECW = 8;

    logic           clk;
    logic           rst_i;
    logic [IDW-1:0] cmd_id_i;
    logic [LW-1:0]  cmd_len_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [DW-1:0]  resp_data_i;
    logic [NB-1:0]  resp_err_i;
    logic [NB-1:0]  resp_exokay_i;
    logic           resp_valid_i;
    logic           resp_ready_o;
    logic [IDW-1:0] r_id_o;
    logic [DW-1:0]  r_data_o;
    logic [1:0]     r_resp_o;
    logic           r_last_o;
    logic           r_valid_o;
    logic           r_ready_i;
    logic           err_clr_i;
    logic [ECW-1:0] err_cnt_o;

    int tests;
    int fails;
    int exp_err;

    axi_r_beat_packer #(
        .DATA_WIDTH   (DW),
        .NUM_BANKS    (NB),
        .ID_WIDTH     (IDW),
        .LEN_WIDTH    (LW),
        .ERR_CNT_WIDTH(ECW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_id_i     (cmd_id_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .resp_data_i  (resp_data_i),
        .resp_err_i   (resp_err_i),
        .resp_exokay_i(resp_exokay_i),
        .resp_valid_i (resp_valid_i),
        .resp_ready_o (resp_ready_o),
        .r_id_o       (r_id_o),
        .r_data_o     (r_data_o),
        .r_resp_o     (r_resp_o),
        .r_last_o     (r_last_o),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i),
        .err_clr_i    (err_clr_i),
        .err_cnt_o    (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [IDW-1:0] id, input logic [LW-1:0] len);
        check("cmd_ready_before_cmd", 64'(cmd_ready_o), 64'd1);
        cmd_id_i    = id;
        cmd_len_i   = len;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        check("cmd_ready_in_burst", 64'(cmd_ready_o), 64'd0);
    endtask

    task automatic set_resp(input logic [DW-1:0] d, input logic [NB-1:0] e,
                            input logic [NB-1:0] x);
        resp_valid_i  = 1'b1;
        resp_data_i   = d;
        resp_err_i    = e;
        resp_exokay_i = x;
    endtask

    task automatic check_beat(input string tag, input logic [IDW-1:0] id,
                              input logic [DW-1:0] d, input logic [1:0] rs,
                              input logic last);
        check({tag, "_valid"}, 64'(r_valid_o), 64'd1);
        check({tag, "_id"}, 64'(r_id_o), 64'(id));
        check({tag, "_data"}, 64'(r_data_o), 64'(d));
        check({tag, "_resp"}, 64'(r_resp_o), 64'(rs));
        check({tag, "_last"}, 64'(r_last_o), 64'(last));
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_i         = 1'b1;
        cmd_id_i      = '0;
        cmd_len_i     = '0;
        cmd_valid_i   = 1'b0;
        resp_data_i   = '0;
        resp_err_i    = '0;
        resp_exokay_i = '0;
        resp_valid_i  = 1'b0;
        r_ready_i     = 1'b1;
        err_clr_i     = 1'b0;

        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_r_valid", 64'(r_valid_o), 64'd0);
        check("rst_r_id", 64'(r_id_o), 64'd0);
        check("rst_r_data", 64'(r_data_o), 64'd0);
        check("rst_r_resp", 64'(r_resp_o), 64'd0);
        check("rst_r_last", 64'(r_last_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_resp_ready", 64'(resp_ready_o), 64'd0);

        // Single-beat burst.
        send_cmd(4'd3, 8'd0);
        check("t1_resp_ready", 64'(resp_ready_o), 64'd1);
        check("t1_valid_pre", 64'(r_valid_o), 64'd0);
        set_resp(32'hA5A5A5A5, 2'b00, 2'b00);
        tick();
        resp_valid_i = 1'b0;
        check_beat("t1_beat", 4'd3, 32'hA5A5A5A5, 2'b00, 1'b1);
        check("t1_idle", 64'(cmd_ready_o), 64'd1);
        tick();
        check("t1_drained", 64'(r_valid_o), 64'd0);

        // Four back-to-back beats.
        send_cmd(4'd1, 8'd3);
        for (int i = 0; i < 4; i++) begin
            set_resp(32'h100 + 32'(i), 2'b00, 2'b00);
            tick();
            check_beat("t2_beat", 4'd1, 32'h100 + 32'(i), 2'b00, i == 3);
        end
        resp_valid_i = 1'b0;

        // Stall after beat 1; beat 4 of previous burst drains here.
        send_cmd(4'd2, 8'd3);
        check("t3_prev_drained", 64'(r_valid_o), 64'd0);
        set_resp(32'h200, 2'b00, 2'b00);
        tick();
        check_beat("t3_b1", 4'd2, 32'h200, 2'b00, 1'b0);
        r_ready_i = 1'b0;
        set_resp(32'h201, 2'b00, 2'b00);
        #1;
        check("t3_stall_ready", 64'(resp_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_beat("t3_hold", 4'd2, 32'h200, 2'b00, 1'b0);
            check("t3_hold_ready", 64'(resp_ready_o), 64'd0);
        end
        r_ready_i = 1'b1;
        #1;
        check("t3_release_ready", 64'(resp_ready_o), 64'd1);
        for (int i = 1; i < 4; i++) begin
            set_resp(32'h200 + 32'(i), 2'b00, 2'b00);
            tick();
            check_beat("t3_beat", 4'd2, 32'h200 + 32'(i), 2'b00, i == 3);
        end
        resp_valid_i = 1'b0;

        // Resp encoding and error counter.
        send_cmd(4'd4, 8'd2);
        set_resp(32'h300, 2'b00, 2'b11);
        tick();
        check_beat("t4_b1", 4'd4, 32'h300, 2'b01, 1'b0);
        set_resp(32'h301, 2'b01, 2'b11);
        tick();
        check_beat("t4_b2", 4'd4, 32'h301, 2'b10, 1'b0);
        check("t4_cnt_before", 64'(err_cnt_o), 64'd0);
        set_resp(32'h302, 2'b00, 2'b11);
        tick();
        check_beat("t4_b3", 4'd4, 32'h302, 2'b01, 1'b1);
        check("t4_cnt_after", 64'(err_cnt_o), 64'd1);
        resp_valid_i = 1'b0;

        send_cmd(4'd6, 8'd1);
        set_resp(32'h400, 2'b00, 2'b01);
        tick();
        check_beat("t4_partial_exok", 4'd6, 32'h400, 2'b00, 1'b0);
        set_resp(32'h401, 2'b10, 2'b00);
        tick();
        check_beat("t4_err_bank1", 4'd6, 32'h401, 2'b10, 1'b1);
        check("t4_cnt_hold", 64'(err_cnt_o), 64'd1);
        resp_valid_i = 1'b0;
        err_clr_i    = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("t4_clr_wins", 64'(err_cnt_o), 64'd0);

        // Reset after beat 2 of an 8-beat burst.
        send_cmd(4'd7, 8'd7);
        set_resp(32'h500, 2'b01, 2'b00);
        tick();
        set_resp(32'h501, 2'b01, 2'b00);
        tick();
        check_beat("t5_b2", 4'd7, 32'h501, 2'b10, 1'b0);
        check("t5_cnt_pre", 64'(err_cnt_o), 64'd1);
        resp_valid_i = 1'b0;
        rst_i        = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("t5_valid", 64'(r_valid_o), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("t5_cnt", 64'(err_cnt_o), 64'd0);
        check("t5_last", 64'(r_last_o), 64'd0);
        send_cmd(4'd5, 8'd1);
        for (int i = 0; i < 2; i++) begin
            set_resp(32'h600 + 32'(i), 2'b00, 2'b00);
            tick();
            check_beat("t5_new", 4'd5, 32'h600 + 32'(i), 2'b00, i == 1);
        end
        resp_valid_i = 1'b0;

        // 256-beat burst of SLVERR beats; counter saturates at all-ones.
        send_cmd(4'd9, 8'd255);
        for (int i = 0; i < 256; i++) begin
            set_resp(32'hD0000000 | 32'(i), 2'b11, 2'b00);
            tick();
            exp_err = (i > 255) ? 255 : i;
            check("t6_valid", 64'(r_valid_o), 64'd1);
            check("t6_data", 64'(r_data_o), 64'(32'hD0000000 | 32'(i)));
            check("t6_last", 64'(r_last_o), 64'(i == 255));
            check("t6_cmd_ready", 64'(cmd_ready_o), 64'(i == 255));
            check("t6_err_cnt", 64'(err_cnt_o), 64'(exp_err));
        end
        resp_valid_i = 1'b0;
        tick();
        check("t6_drained", 64'(r_valid_o), 64'd0);
        check("t6_err_sat", 64'(err_cnt_o), 64'hFF);
        tick();
        check("t6_err_hold", 64'(err_cnt_o), 64'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
